systolic_result_collector: RTL and testbench

//  Receiving end of the systolic array result interface. Row m of the array output carries result k
//  m cycles after row 0 does. The block de-skews the rows into aligned vectors, buffers them in a FIFO,
//  and writes them to the output buffer over a valid/ready port with auto-incrementing addresses.

---
 rtl/systolic_result_collector.sv | 201 ++++++++++++++++++++
 tb/tb_systolic_result_collector.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : systolic_result_collector
// Purpose  : Receiving end of the systolic array result interface. De-skews
//            the staggered result rows into aligned vectors, buffers them in
//            a show-ahead FIFO and writes them to the output buffer over a
//            valid/ready port with auto-incrementing, wrapping addresses.
// Options  : COLLECTOR_RELU_EN - when defined, every lane is clamped to zero
//            if negative (signed) as it is written into the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_result_collector #(
    parameter int ARRAY_M      = 16,
    parameter int PE_OUT_WIDTH = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_start,
    input  logic [CNT_WIDTH-1:0]            cfg_num_vec,
    input  logic [ADDR_WIDTH-1:0]           cfg_base_addr,
    input  logic                            res_valid_in,
    input  logic [ARRAY_M*PE_OUT_WIDTH-1:0] res_data_in,
    output logic                            obuf_wr_valid,
    input  logic                            obuf_wr_ready,
    output logic [ADDR_WIDTH-1:0]           obuf_wr_addr,
    output logic [ARRAY_M*PE_OUT_WIDTH-1:0] obuf_wr_data,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow_err
);

    localparam int c_DW = ARRAY_M * PE_OUT_WIDTH;
    localparam int c_PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [c_PW:0]         c_PTR_ONE  = (c_PW + 1)'(1);

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  w_collect;
    logic                  w_start_ok;
    logic [CNT_WIDTH-1:0]  r_num_vec;
    logic [CNT_WIDTH-1:0]  r_in_cnt;
    logic [CNT_WIDTH-1:0]  r_al_cnt;
    logic                  w_in_valid;
    logic [ARRAY_M-2:0]    r_vld_sr;
    logic [c_DW-1:0]       w_aligned;
    logic                  r_pv;
    logic [c_DW-1:0]       r_pdata;
    logic [c_DW-1:0]       w_fifo_din;
    logic [c_DW-1:0]       r_mem [FIFO_DEPTH];
    logic [c_PW:0]         r_wptr;
    logic [c_PW:0]         r_rptr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_drop;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ovf;

    assign w_start_ok = cfg_start && (r_state == c_IDLE);
    assign w_collect  = (r_state == c_COLLECT);
    // Only the first num_vec row-0 valids of a COLLECT phase enter the pipe.
    assign w_in_valid = res_valid_in && w_collect && (r_in_cnt != r_num_vec);

    // Lane m is delayed ARRAY_M-1-m cycles so all lanes of a result line up.
    for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
        localparam int c_DLY = ARRAY_M - 1 - m;
        if (c_DLY == 0) begin : g_pass
            assign w_aligned[m*PE_OUT_WIDTH +: PE_OUT_WIDTH] = res_data_in[m*PE_OUT_WIDTH +: PE_OUT_WIDTH];
        end else begin : g_dly
            logic [PE_OUT_WIDTH-1:0] r_dly [c_DLY];
            // Lane delay line
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < c_DLY; i++) r_dly[i] <= '0;
                end else begin
                    r_dly[0] <= res_data_in[m*PE_OUT_WIDTH +: PE_OUT_WIDTH];
                    for (int i = 1; i < c_DLY; i++) r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_aligned[m*PE_OUT_WIDTH +: PE_OUT_WIDTH] = r_dly[c_DLY-1];
        end
    end

    // Valid delay line matching lane 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_sr <= '0;
        end else begin
            r_vld_sr[0] <= w_in_valid;
            for (int i = 1; i < ARRAY_M - 1; i++) r_vld_sr[i] <= r_vld_sr[i-1];
        end
    end

    // Aligned-vector stage in front of the FIFO; gives the fixed ARRAY_M+1 latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pv    <= 1'b0;
            r_pdata <= '0;
        end else begin
            r_pv    <= r_vld_sr[ARRAY_M-2];
            r_pdata <= w_aligned;
        end
    end

`ifdef COLLECTOR_RELU_EN
    for (genvar m = 0; m < ARRAY_M; m++) begin : g_relu
        assign w_fifo_din[m*PE_OUT_WIDTH +: PE_OUT_WIDTH] =
            r_pdata[m*PE_OUT_WIDTH + PE_OUT_WIDTH - 1] ? '0 : r_pdata[m*PE_OUT_WIDTH +: PE_OUT_WIDTH];
    end
`else
    assign w_fifo_din = r_pdata;
`endif

    // FIFO status; a write into a full FIFO is fine when a read frees a slot
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_PW] != r_rptr[c_PW]) && (r_wptr[c_PW-1:0] == r_rptr[c_PW-1:0]);
    assign w_rd    = !w_empty && obuf_wr_ready;
    assign w_wr    = r_pv && (!w_full || w_rd);
    assign w_drop  = r_pv && w_full && !w_rd;

    // FIFO pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_rd) r_rptr <= r_rptr + c_PTR_ONE;
        end
    end

    // FIFO storage; emptiness is carried by the pointers alone
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[c_PW-1:0]] <= w_fifo_din;
    end

    // Configuration latch, input/aligned counters, write address, sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_vec <= '0;
            r_in_cnt  <= '0;
            r_al_cnt  <= '0;
            r_addr    <= '0;
            r_ovf     <= 1'b0;
        end else if (w_start_ok) begin
            r_num_vec <= cfg_num_vec;
            r_in_cnt  <= '0;
            r_al_cnt  <= '0;
            r_addr    <= cfg_base_addr;
            r_ovf     <= 1'b0;
        end else begin
            if (w_in_valid)           r_in_cnt <= r_in_cnt + c_CNT_ONE;
            if (r_pv && w_collect)    r_al_cnt <= r_al_cnt + c_CNT_ONE;
            if (w_rd)                 r_addr   <= r_addr + c_ADDR_ONE;
            if (w_drop)               r_ovf    <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next_state;
    end

    // FSM next-state logic; dropped vectors count toward num_vec too
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (cfg_start) w_next_state = (cfg_num_vec == '0) ? c_DONE : c_COLLECT;
            c_COLLECT: if (r_pv && (r_al_cnt == r_num_vec - c_CNT_ONE)) w_next_state = c_DRAIN;
            c_DRAIN:   if (w_empty && !r_pv) w_next_state = c_DONE;
            c_DONE:    w_next_state = c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state != c_IDLE);
        done = (r_state == c_DONE);
    end

    assign obuf_wr_valid = !w_empty;
    assign obuf_wr_addr  = r_addr;
    assign obuf_wr_data  = w_empty ? '0 : r_mem[r_rptr[c_PW-1:0]];
    assign overflow_err  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_result_collector
// Purpose  : Self-checking bench for systolic_result_collector: directed
//            scenarios with literal expectations plus randomized runs checked
//            every cycle against a queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_result_collector;

    localparam int M     = 4;
    localparam int W     = 32;
    localparam int D     = 4;
    localparam int AW    = 12;
    localparam int CW    = 16;
    localparam int DW    = M * W;
    localparam int NPLAN = 8192;

    logic          clk           = 1'b0;
    logic          reset         = 1'b0;
    logic          cfg_start     = 1'b0;
    logic [CW-1:0] cfg_num_vec   = '0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic          res_valid_in  = 1'b0;
    logic [DW-1:0] res_data_in   = '0;
    logic          obuf_wr_ready = 1'b1;
    logic          obuf_wr_valid;
    logic [AW-1:0] obuf_wr_addr;
    logic [DW-1:0] obuf_wr_data;
    logic          busy;
    logic          done;
    logic          overflow_err;

    int n_cmp = 0;
    int n_bad = 0;

    systolic_result_collector #(
        .ARRAY_M(M), .PE_OUT_WIDTH(W), .FIFO_DEPTH(D), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_num_vec(cfg_num_vec),
        .cfg_base_addr(cfg_base_addr), .res_valid_in(res_valid_in), .res_data_in(res_data_in),
        .obuf_wr_valid(obuf_wr_valid), .obuf_wr_ready(obuf_wr_ready), .obuf_wr_addr(obuf_wr_addr),
        .obuf_wr_data(obuf_wr_data), .busy(busy), .done(done), .overflow_err(overflow_err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus plan: skewed lanes stored per cycle ----------
    bit            plan_v [NPLAN];
    logic [DW-1:0] plan_d [NPLAN];
    int            cyc = 0;

    function automatic logic [DW-1:0] rnd_bus();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] vec_lit(input int k);
        logic [DW-1:0] v;
        for (int m = 0; m < M; m++) v[m*W +: W] = W'(100 * k + m);
        return v;
    endfunction

    // Vector whose row 0 appears at cycle c; lane m shows up m cycles later.
    task automatic sched_vec(input int c, input logic [DW-1:0] v);
        plan_v[c] = 1'b1;
        for (int m = 0; m < M; m++) plan_d[c+m][m*W +: W] = v[m*W +: W];
    endtask

    task automatic clear_plan();
        for (int i = cyc + 1; i < NPLAN; i++) plan_v[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NPLAN; i++) begin
            plan_v[i] = 1'b0;
            plan_d[i] = rnd_bus();
        end
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (cyc >= NPLAN - 16) begin
                $display("FAIL plan_overrun: cyc=%0d limit=%0d", cyc, NPLAN - 16);
                $fatal(1);
            end
            res_valid_in = plan_v[cyc];
            res_data_in  = plan_d[cyc];
        end
    end

    // ---------------- behavioural model -------------------------------------
    // ms: 0 idle, 1 collect, 2 drain, 3 done. A vector accepted at edge e is
    // assembled from the lanes seen at edges e..e+M-1 and enters the queue at
    // edge e+M (visible to the writer one cycle later).
    logic [DW-1:0] hist [64];
    bit            arrive [64];
    logic [DW-1:0] mq [$];
    int            ms = 0;
    int            mnum = 0, min_cnt = 0, mal_cnt = 0, ecount = 0;
    logic [AW-1:0] maddr = '0;
    bit            movf = 1'b0;
    int            m_sz0;
    bit            m_rd, m_wr;
    logic [DW-1:0] m_v;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            ms = 0; mnum = 0; min_cnt = 0; mal_cnt = 0;
            maddr = '0; movf = 1'b0;
            for (int i = 0; i < 64; i++) arrive[i] = 1'b0;
        end else begin
            m_sz0 = mq.size();
            hist[ecount % 64] = res_data_in;
            m_rd = (m_sz0 > 0) && obuf_wr_ready;
            m_wr = arrive[ecount % 64];
            arrive[ecount % 64] = 1'b0;
            if (m_rd) begin
                void'(mq.pop_front());
                maddr = maddr + 1'b1;
            end
            if (m_wr) begin
                for (int m = 0; m < M; m++) m_v[m*W +: W] = hist[(ecount - M + m) % 64][m*W +: W];
`ifdef COLLECTOR_RELU_EN
                for (int m = 0; m < M; m++) if (m_v[m*W + W - 1]) m_v[m*W +: W] = '0;
`endif
                mal_cnt++;
                if (mq.size() < D) mq.push_back(m_v);
                else movf = 1'b1;
            end
            case (ms)
                0: if (cfg_start) begin
                       mnum = cfg_num_vec; maddr = cfg_base_addr;
                       min_cnt = 0; mal_cnt = 0; movf = 1'b0;
                       ms = (mnum == 0) ? 3 : 1;
                   end
                1: begin
                       if (res_valid_in && min_cnt < mnum) begin
                           min_cnt++;
                           arrive[(ecount + M) % 64] = 1'b1;
                       end
                       if (m_wr && mal_cnt == mnum) ms = 2;
                   end
                2: if (m_sz0 == 0) ms = 3;
                default: ms = 0;
            endcase
            ecount++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_valid", obuf_wr_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_ovf", overflow_err, 1'b0);
            chk("rst_addr", obuf_wr_addr, '0);
        end else begin
            chk("mdl_valid", obuf_wr_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("mdl_addr", obuf_wr_addr, maddr);
                chk("mdl_data", obuf_wr_data, mq[0]);
            end
            chk("mdl_busy", busy, ms != 0);
            chk("mdl_done", done, ms == 3);
            chk("mdl_ovf", overflow_err, movf);
        end
    end

    // ---------------- directed sequencing helpers ---------------------------
    logic [AW-1:0] log_a [$];
    logic [DW-1:0] log_d [$];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input int num, input int base);
        cfg_num_vec   = CW'(num);
        cfg_base_addr = AW'(base);
        cfg_start     = 1'b1;
        step();
        cfg_start     = 1'b0;
    endtask

    task automatic run_log(input int max_cyc, input bit rnd_ready);
        bit fin;
        fin = 1'b0;
        log_a.delete();
        log_d.delete();
        for (int i = 0; i < max_cyc && !fin; i++) begin
            if (rnd_ready) obuf_wr_ready = ($urandom_range(0, 3) != 0);
            if (obuf_wr_valid && obuf_wr_ready) begin
                log_a.push_back(obuf_wr_addr);
                log_d.push_back(obuf_wr_data);
            end
            if (done) fin = 1'b1;
            step();
        end
        chk("run_complete", fin, 1'b1);
        obuf_wr_ready = 1'b1;
    endtask

    task automatic chk_log(input string name, input int n, input int base, input int k0);
        chk({name, "_count"}, log_a.size(), n);
        for (int j = 0; j < n && j < log_a.size(); j++) begin
            chk({name, "_addr"}, log_a[j], AW'(base + j));
            chk({name, "_data"}, log_d[j], vec_lit(k0 + j));
        end
    endtask

    // ---------------- main sequence ------------------------------------------
    initial begin
        int c;
        #1 reset = 1'b1;
        repeat (3) step();
        chk("init_valid", obuf_wr_valid, 1'b0);
        chk("init_busy", busy, 1'b0);
        reset = 1'b0;
        step();

        // Basic collect: three skewed vectors, ready high, latency M+1
        start(3, 'h10);
        c = cyc + 1;
        for (int k = 0; k < 3; k++) sched_vec(c + k, vec_lit(k));
        chk("t1_busy", busy, 1'b1);
        while (cyc < c + M) step();
        chk("t1_lat_before", obuf_wr_valid, 1'b0);
        step();
        chk("t1_lat_at", obuf_wr_valid, 1'b1);
        run_log(100, 1'b0);
        chk_log("t1", 3, 'h10, 0);
        chk("t1_done_once", done, 1'b0);

        // Backpressure for 10 cycles: nothing lost, order kept
        start(3, 'h10);
        obuf_wr_ready = 1'b0;
        c = cyc + 1;
        for (int k = 0; k < 3; k++) sched_vec(c + k, vec_lit(k));
        repeat (10) step();
        chk("t2_held_valid", obuf_wr_valid, 1'b1);
        chk("t2_held_data", obuf_wr_data, vec_lit(0));
        obuf_wr_ready = 1'b1;
        run_log(100, 1'b0);
        chk_log("t2", 3, 'h10, 0);
        chk("t2_no_ovf", overflow_err, 1'b0);

        // Overflow: D+2 vectors while stalled -> D kept, sticky error, DRAIN
        start(D + 2, 'h20);
        obuf_wr_ready = 1'b0;
        c = cyc + 1;
        for (int k = 0; k < D + 2; k++) sched_vec(c + k, vec_lit(k));
        repeat (16) step();
        chk("t3_ovf", overflow_err, 1'b1);
        chk("t3_busy", busy, 1'b1);
        chk("t3_held_data", obuf_wr_data, vec_lit(0));
        chk("t3_held_addr", obuf_wr_addr, AW'('h20));
        obuf_wr_ready = 1'b1;
        run_log(100, 1'b0);
        chk_log("t3", D, 'h20, 0);

        // num_vec = 0: one busy cycle with done, no writes
        start(0, 'h30);
        chk("t4_busy", busy, 1'b1);
        chk("t4_done", done, 1'b1);
        chk("t4_valid", obuf_wr_valid, 1'b0);
        step();
        chk("t4_busy_after", busy, 1'b0);
        chk("t4_done_after", done, 1'b0);

        // Address wrap
        start(2, 'hFFF);
        c = cyc + 1;
        sched_vec(c, vec_lit(7));
        sched_vec(c + 1, vec_lit(8));
        run_log(100, 1'b0);
        chk("t5_count", log_a.size(), 2);
        if (log_a.size() == 2) begin
            chk("t5_addr0", log_a[0], AW'('hFFF));
            chk("t5_addr1", log_a[1], AW'('h000));
            chk("t5_data1", log_d[1], vec_lit(8));
        end

        // Ignored restart during COLLECT, then abort by reset after 2 of 4
        start(4, 'h40);
        c = cyc + 1;
        for (int k = 0; k < 4; k++) sched_vec(c + 3 * k, vec_lit(k));
        cfg_num_vec = CW'(1); cfg_base_addr = AW'('h99); cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        log_a.delete();
        log_d.delete();
        for (int i = 0; i < 60 && log_a.size() < 2; i++) begin
            if (obuf_wr_valid && obuf_wr_ready) begin
                log_a.push_back(obuf_wr_addr);
                log_d.push_back(obuf_wr_data);
            end
            step();
        end
        chk_log("t6", 2, 'h40, 0);
        chk("t6_busy_before_rst", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", obuf_wr_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_data", obuf_wr_data, '0);
        chk("t6_rst_addr", obuf_wr_addr, '0);
        clear_plan();
        repeat (2) step();
        reset = 1'b0;
        step();
        chk("t6_idle_valid", obuf_wr_valid, 1'b0);
        start(2, 'h50);
        c = cyc + 1;
        sched_vec(c, vec_lit(5));
        sched_vec(c + 1, vec_lit(6));
        run_log(100, 1'b0);
        chk_log("t6_restart", 2, 'h50, 5);

        // Randomized runs against the model
        for (int r = 0; r < 25; r++) begin
            int num;
            num = $urandom_range(1, 8);
            start(num, $urandom_range(0, (1 << AW) - 1));
            c = cyc + 1 + $urandom_range(0, 2);
            for (int k = 0; k < num + $urandom_range(0, 1); k++) begin
                sched_vec(c, rnd_bus());
                c = c + $urandom_range(1, 3);
            end
            if ($urandom_range(0, 1) == 1) begin
                cfg_num_vec = CW'($urandom_range(0, 9));
                cfg_base_addr = AW'($urandom);
                cfg_start = 1'b1;
                step();
                cfg_start = 1'b0;
            end
            run_log(400, 1'b1);
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
